ld_ramp_ctrl: RTL and testbench
===============================

# ld_ramp_ctrl

Parametrised laser-diode current ramp controller, the next generation of the LD driver ASM. It converts the front-panel enable (SW_ON) and the laser request (LD_ON) into a soft-started, soft-stopped drive code I_out for the current DAC. The step timebase is internal; the block no longer needs an external counter. Compared with the previous driver it adds saturating arithmetic, live setpoint tracking in both directions, a minimum step of 1, and a latched FAULT shutdown.

## Interface
- W, 13: width of the current codes.
- STEP_SHIFT, 10: up-step is I_set_reg >> STEP_SHIFT, with a minimum of 1.
- DN_SHIFT, 1: down-step is up-step << DN_SHIFT.
- TICK_DIV, 4: clock cycles per ramp step; must be at least 2.

- CLK  in  1  clock; all logic on rising edge.
- Clr  in  1  synchronous, active-high reset.
- SW_ON  in  1  master enable.
- LD_ON  in  1  laser request.
- FAULT  in  1  interlock; sampled synchronously.
- I_set  in  W  target current code.
- I_out  out  W  DAC drive code.
- state  out  3  current state code.
- at_set  out  1  high when state == HOLD.
- busy  out  1  high in UP, TRIM_DN or OFF_DN.
- fault_latched  out  1  high when state == FAULT.

## Operation
- Input registers, updated every cycle:
  - en_reg <= SW_ON & LD_ON.
  - I_set_reg <= I_set.
- Step sizes:
  - inc = max(I_set_reg >> STEP_SHIFT, 1).
  - dec = inc << DN_SHIFT.
  - Both are computed at W+DN_SHIFT bits, so no truncation occurs before the compare.
- States: IDLE=0, UP=1, HOLD=2, TRIM_DN=3, OFF_DN=4, FAULT=5. Codes 6 and 7 go to IDLE on the next edge with I_out <= 0.
- Transitions are evaluated from current registers. FAULT=1 overrides everything: next state is FAULT and I_out <= 0 on the same edge.
  - IDLE: en_reg -> UP. I_out is held at 0.
  - UP: !en_reg -> OFF_DN; I_out == I_set_reg -> HOLD; I_out > I_set_reg -> TRIM_DN.
  - HOLD: !en_reg -> OFF_DN; I_out < I_set_reg -> UP; I_out > I_set_reg -> TRIM_DN.
  - TRIM_DN: !en_reg -> OFF_DN; equal -> HOLD; I_out < I_set_reg -> UP.
  - OFF_DN: en_reg -> UP; I_out == 0 -> IDLE.
  - FAULT: leave only when FAULT=0 and SW_ON=0 (raw input), then -> IDLE. I_out is held at 0.
- Tick counter tcnt counts 0..TICK_DIV-1:
  - It is cleared to 0 whenever next state differs from current state, and in IDLE, HOLD and FAULT.
  - tick = (tcnt == TICK_DIV-1) and next state equals current state.
- Stepping happens only on edges where tick is high:
  - UP: I_out <= min(I_out + inc, I_set_reg).
  - TRIM_DN: I_out <= max(I_out - dec, I_set_reg).
  - OFF_DN: I_out <= (I_out > dec) ? I_out - dec : 0.
- No wrap-around is permitted in either direction. I_out never exceeds I_set_reg while ramping up and never goes below 0.

## Timing
- Reset values: state=IDLE, I_out=0, tcnt=0, en_reg=0, I_set_reg=0, at_set=0, busy=0, fault_latched=0.
- Reset asserted mid-ramp forces all of the above on the next edge.
- Enable latency: SW_ON&LD_ON rise at edge N registers en_reg; state becomes UP at edge N+1; the first step lands at edge N+1+TICK_DIV.
- The step period is TICK_DIV cycles. Each state change costs one extra cycle before that state's first tick.
- Setpoint latency: a change in I_set reaches I_set_reg one edge later; the state reacts one edge after that.
- FAULT response: a FAULT high sampled at edge N gives I_out=0 and state=FAULT after edge N. The dependent outputs follow state in the same cycle.
- Simultaneous events:
  - FAULT beats Clr=0 logic.
  - Loss of enable beats reaching the setpoint.
  - In OFF_DN, re-enable beats reaching 0.
- state, at_set, busy and fault_latched are decoded combinationally from the state register only.

## Test plan
- Use W=13, STEP_SHIFT=10, DN_SHIFT=1, TICK_DIV=4 throughout.
- Soft start: I_set=2048, raise SW_ON and LD_ON.
  - Required: inc=2; I_out reaches 2048 after 1024 steps.
  - Required: at_set rises exactly 2+1024*4+1 cycles after enable.
- Soft stop: from HOLD at 2048, drop LD_ON.
  - Required: OFF_DN with dec=4; I_out reaches 0 after 512 steps, then state=IDLE and busy=0.
- Small setpoint: I_set=100.
  - Required: inc clamps to 1; ramp goes 0,1,2,...,100 with no overshoot, then HOLD.
- Tracking: in HOLD at 2048, change I_set to 1030.
  - Required: TRIM_DN with dec=2 (1030>>10=1, shifted by 1).
  - Required: I_out clamps exactly at 1030, then HOLD.
  - Then change I_set to 1100. Required: UP, clamped at 1100.
- Saturation: OFF_DN with I_out=3 and dec=4.
  - Required: next step gives I_out=0, not wrap-around; then IDLE.
- Fault and reset:
  - FAULT pulse at I_out=1500 in UP. Required: I_out=0 and fault_latched=1 on the next edge; state stays FAULT while SW_ON=1; returns to IDLE one edge after SW_ON=0.
  - Clr pulse mid-UP. Required: every output is at its reset value after the edge.

Source files
------------

// File: rtl/ld_ramp_ctrl.sv
// ld_ramp_ctrl: laser-diode current ramp controller.
// Soft-starts the DAC drive code towards the setpoint, tracks setpoint changes in
// both directions, soft-stops on loss of enable and latches a FAULT shutdown.
// Arithmetic is carried at WX bits so neither step nor compare can wrap.
module ld_ramp_ctrl #(
    parameter int W          = 13,
    parameter int STEP_SHIFT = 10,
    parameter int DN_SHIFT   = 1,
    parameter int TICK_DIV   = 4
) (
    input  logic         CLK,
    input  logic         Clr,
    input  logic         SW_ON,
    input  logic         LD_ON,
    input  logic         FAULT,
    input  logic [W-1:0] I_set,
    output logic [W-1:0] I_out,
    output logic [2:0]   state,
    output logic         at_set,
    output logic         busy,
    output logic         fault_latched
);

    localparam int WX = W + DN_SHIFT + 1;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD    = 3'd2,
        S_TRIM_DN = 3'd3,
        S_OFF_DN  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  i_out_q, i_out_d;
    logic [W-1:0]  i_set_q, i_set_d;
    logic          en_q, en_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    logic [WX-1:0] set_x, out_x, shr_x, inc_x, dec_x, sum_x;
    logic          out_eq, out_lt, out_gt;

    // Widened operands, step sizes (minimum up-step of 1) and setpoint compares.
    always_comb begin
        set_x  = WX'(i_set_q);
        out_x  = WX'(i_out_q);
        shr_x  = set_x >> STEP_SHIFT;
        inc_x  = (shr_x == '0) ? WX'(1) : shr_x;
        dec_x  = inc_x << DN_SHIFT;
        sum_x  = out_x + inc_x;
        out_eq = (i_out_q == i_set_q);
        out_lt = (i_out_q <  i_set_q);
        out_gt = (i_out_q >  i_set_q);
    end

    // Input capture: enable and setpoint are registered every cycle.
    always_comb begin
        en_d    = SW_ON & LD_ON;
        i_set_d = I_set;
    end

    // Next-state logic; FAULT wins over everything, loss of enable wins over compares.
    always_comb begin
        state_d = state_q;
        if (FAULT) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en_q) state_d = S_UP;
                end
                S_UP: begin
                    if (!en_q)       state_d = S_OFF_DN;
                    else if (out_eq) state_d = S_HOLD;
                    else if (out_gt) state_d = S_TRIM_DN;
                end
                S_HOLD: begin
                    if (!en_q)       state_d = S_OFF_DN;
                    else if (out_lt) state_d = S_UP;
                    else if (out_gt) state_d = S_TRIM_DN;
                end
                S_TRIM_DN: begin
                    if (!en_q)       state_d = S_OFF_DN;
                    else if (out_eq) state_d = S_HOLD;
                    else if (out_lt) state_d = S_UP;
                end
                S_OFF_DN: begin
                    if (en_q)                 state_d = S_UP;
                    else if (i_out_q == '0)   state_d = S_IDLE;
                end
                S_FAULT: begin
                    // FAULT is already known low here; wait for the operator to drop SW_ON.
                    if (!SW_ON) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Step timebase: restarts on every state change so each state gets a full period.
    always_comb begin
        tick = (tcnt_q == TCNT_LAST) && (state_d == state_q);
        if ((state_d != state_q) || (state_q == S_IDLE) ||
            (state_q == S_HOLD) || (state_q == S_FAULT)) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Drive code update: saturating steps on tick, forced to zero in IDLE/FAULT.
    always_comb begin
        i_out_d = i_out_q;
        if (FAULT) begin
            i_out_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_FAULT: i_out_d = '0;
                S_HOLD:          i_out_d = i_out_q;
                S_UP: begin
                    if (tick) begin
                        if (sum_x >= set_x) i_out_d = i_set_q;
                        else                i_out_d = W'(sum_x);
                    end
                end
                S_TRIM_DN: begin
                    if (tick) begin
                        if (out_x >= set_x + dec_x) i_out_d = W'(out_x - dec_x);
                        else                        i_out_d = i_set_q;
                    end
                end
                S_OFF_DN: begin
                    if (tick) begin
                        if (out_x > dec_x) i_out_d = W'(out_x - dec_x);
                        else               i_out_d = '0;
                    end
                end
                default: i_out_d = '0;
            endcase
        end
    end

    // All state registers, synchronous active-high clear.
    always_ff @(posedge CLK) begin
        if (Clr) begin
            state_q <= S_IDLE;
            i_out_q <= '0;
            i_set_q <= '0;
            en_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            i_out_q <= i_out_d;
            i_set_q <= i_set_d;
            en_q    <= en_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Status decode from the state register only.
    assign I_out         = i_out_q;
    assign state         = state_q;
    assign at_set        = (state_q == S_HOLD);
    assign busy          = (state_q == S_UP) || (state_q == S_TRIM_DN) || (state_q == S_OFF_DN);
    assign fault_latched = (state_q == S_FAULT);

endmodule

// File: tb/tb_ld_ramp_ctrl.sv
// tb_ld_ramp_ctrl: directed scenarios for the laser-diode ramp controller.
// Inputs change and outputs are sampled on the falling edge, so every
// @(negedge CLK) corresponds to exactly one active rising edge.
module tb_ld_ramp_ctrl;

    localparam int W = 13;

    logic         CLK;
    logic         Clr;
    logic         SW_ON;
    logic         LD_ON;
    logic         FAULT;
    logic [W-1:0] I_set;
    logic [W-1:0] I_out;
    logic [2:0]   state;
    logic         at_set;
    logic         busy;
    logic         fault_latched;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ld_ramp_ctrl #(
        .W(W), .STEP_SHIFT(10), .DN_SHIFT(1), .TICK_DIV(4)
    ) dut (
        .CLK(CLK), .Clr(Clr), .SW_ON(SW_ON), .LD_ON(LD_ON), .FAULT(FAULT),
        .I_set(I_set), .I_out(I_out), .state(state), .at_set(at_set),
        .busy(busy), .fault_latched(fault_latched)
    );

    // Clock generation.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic test_reset();
        Clr = 1'b1; SW_ON = 1'b0; LD_ON = 1'b0; FAULT = 1'b0; I_set = '0;
        repeat (3) @(negedge CLK);
        chk_cnt++; if (I_out !== 13'd0) $display("FAIL reset_i_out got=%0d exp=0", I_out); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if ({at_set, busy, fault_latched} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {at_set, busy, fault_latched}); else pass_cnt++;
        Clr = 1'b0;
        @(negedge CLK);
        chk_cnt++; if (state !== 3'd0) $display("FAIL reset_idle_stays got=%0d exp=0", state); else pass_cnt++;
    endtask

    task automatic test_soft_start();
        int n = 0;
        logic [2:0] st2 = 'x;
        logic [W-1:0] out5 = 'x, out6 = 'x;
        logic over = 1'b0;
        I_set = 13'd2048; SW_ON = 1'b1; LD_ON = 1'b1;
        while (at_set !== 1'b1 && n < 6000) begin
            @(negedge CLK); n++;
            if (n == 2) st2 = state;
            if (n == 5) out5 = I_out;
            if (n == 6) out6 = I_out;
            if (I_out > 13'd2048) over = 1'b1;
        end
        chk_cnt++; if (n !== 4099) $display("FAIL start_at_set_latency got=%0d exp=4099", n); else pass_cnt++;
        chk_cnt++; if (st2 !== 3'd1) $display("FAIL start_state_up got=%0d exp=1", st2); else pass_cnt++;
        chk_cnt++; if (out5 !== 13'd0) $display("FAIL start_before_first_step got=%0d exp=0", out5); else pass_cnt++;
        chk_cnt++; if (out6 !== 13'd2) $display("FAIL start_first_step got=%0d exp=2", out6); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd2048) $display("FAIL start_final got=%0d exp=2048", I_out); else pass_cnt++;
        chk_cnt++; if (over !== 1'b0) $display("FAIL start_overshoot got=%b exp=0", over); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL start_hold_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_soft_stop();
        int n = 0;
        logic [2:0] st2 = 'x;
        logic busy2 = 1'bx;
        logic [W-1:0] out6 = 'x;
        LD_ON = 1'b0;
        while (state !== 3'd0 && n < 4000) begin
            @(negedge CLK); n++;
            if (n == 2) begin st2 = state; busy2 = busy; end
            if (n == 6) out6 = I_out;
        end
        chk_cnt++; if (n !== 2051) $display("FAIL stop_latency got=%0d exp=2051", n); else pass_cnt++;
        chk_cnt++; if (st2 !== 3'd4) $display("FAIL stop_state_off_dn got=%0d exp=4", st2); else pass_cnt++;
        chk_cnt++; if (busy2 !== 1'b1) $display("FAIL stop_busy got=%b exp=1", busy2); else pass_cnt++;
        chk_cnt++; if (out6 !== 13'd2044) $display("FAIL stop_first_step got=%0d exp=2044", out6); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd0) $display("FAIL stop_final got=%0d exp=0", I_out); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL stop_idle_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_small_setpoint();
        int n = 0;
        int steps = 0;
        logic bad = 1'b0;
        logic [W-1:0] prev = '0;
        I_set = 13'd100; LD_ON = 1'b1;
        while (at_set !== 1'b1 && n < 1000) begin
            @(negedge CLK); n++;
            if (I_out !== prev) begin
                if (I_out !== prev + 13'd1) bad = 1'b1;
                steps++;
                prev = I_out;
            end
        end
        chk_cnt++; if (n !== 403) $display("FAIL small_latency got=%0d exp=403", n); else pass_cnt++;
        chk_cnt++; if (steps !== 100) $display("FAIL small_step_count got=%0d exp=100", steps); else pass_cnt++;
        chk_cnt++; if (bad !== 1'b0) $display("FAIL small_unit_steps got=%b exp=0", bad); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd100) $display("FAIL small_final got=%0d exp=100", I_out); else pass_cnt++;
    endtask

    task automatic test_tracking();
        int n = 0;
        logic [2:0] st2 = 'x;
        logic [W-1:0] out6 = 'x;
        logic [W-1:0] lo = '1;
        logic [W-1:0] hi = '0;
        // Climb from HOLD at 100 back to 2048.
        I_set = 13'd2048;
        while (!(at_set === 1'b1 && n > 2) && n < 5000) begin @(negedge CLK); n++; end
        chk_cnt++; if (n !== 3899) $display("FAIL track_reclimb_latency got=%0d exp=3899", n); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd2048) $display("FAIL track_reclimb_final got=%0d exp=2048", I_out); else pass_cnt++;
        // Setpoint down to 1030: trim with dec=2.
        n = 0; I_set = 13'd1030;
        while (!(at_set === 1'b1 && n > 2) && n < 5000) begin
            @(negedge CLK); n++;
            if (n == 2) st2 = state;
            if (n == 6) out6 = I_out;
            if (I_out < lo) lo = I_out;
        end
        chk_cnt++; if (st2 !== 3'd3) $display("FAIL track_state_trim got=%0d exp=3", st2); else pass_cnt++;
        chk_cnt++; if (out6 !== 13'd2046) $display("FAIL track_trim_step got=%0d exp=2046", out6); else pass_cnt++;
        chk_cnt++; if (n !== 2039) $display("FAIL track_trim_latency got=%0d exp=2039", n); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd1030) $display("FAIL track_trim_final got=%0d exp=1030", I_out); else pass_cnt++;
        chk_cnt++; if (lo !== 13'd1030) $display("FAIL track_trim_min got=%0d exp=1030", lo); else pass_cnt++;
        // Setpoint up to 1100: ramp with inc=1.
        n = 0; st2 = 'x; I_set = 13'd1100;
        while (!(at_set === 1'b1 && n > 2) && n < 5000) begin
            @(negedge CLK); n++;
            if (n == 2) st2 = state;
            if (I_out > hi) hi = I_out;
        end
        chk_cnt++; if (st2 !== 3'd1) $display("FAIL track_state_up got=%0d exp=1", st2); else pass_cnt++;
        chk_cnt++; if (n !== 283) $display("FAIL track_up_latency got=%0d exp=283", n); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd1100) $display("FAIL track_up_final got=%0d exp=1100", I_out); else pass_cnt++;
        chk_cnt++; if (hi !== 13'd1100) $display("FAIL track_up_max got=%0d exp=1100", hi); else pass_cnt++;
    endtask

    task automatic test_saturation();
        int n = 0;
        logic [2:0] st2 = 'x;
        logic [W-1:0] out5 = 'x, out6 = 'x;
        logic [W-1:0] hi = '0;
        LD_ON = 1'b0;
        while (state !== 3'd0 && n < 3000) begin @(negedge CLK); n++; end
        chk_cnt++; if (state !== 3'd0) $display("FAIL sat_wind_down got=%0d exp=0", state); else pass_cnt++;
        n = 0; I_set = 13'd3; LD_ON = 1'b1;
        while (at_set !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        chk_cnt++; if (I_out !== 13'd3) $display("FAIL sat_hold_at_3 got=%0d exp=3", I_out); else pass_cnt++;
        // Raise setpoint so dec becomes 4, and drop enable together.
        n = 0; I_set = 13'd2048; LD_ON = 1'b0;
        while (state !== 3'd0 && n < 50) begin
            @(negedge CLK); n++;
            if (n == 2) st2 = state;
            if (n == 5) out5 = I_out;
            if (n == 6) out6 = I_out;
            if (I_out > hi) hi = I_out;
        end
        chk_cnt++; if (st2 !== 3'd4) $display("FAIL sat_state_off_dn got=%0d exp=4", st2); else pass_cnt++;
        chk_cnt++; if (out5 !== 13'd3) $display("FAIL sat_before_step got=%0d exp=3", out5); else pass_cnt++;
        chk_cnt++; if (out6 !== 13'd0) $display("FAIL sat_step_to_zero got=%0d exp=0", out6); else pass_cnt++;
        chk_cnt++; if (hi !== 13'd3) $display("FAIL sat_no_wrap got=%0d exp=3", hi); else pass_cnt++;
        chk_cnt++; if (n !== 7) $display("FAIL sat_idle_latency got=%0d exp=7", n); else pass_cnt++;
    endtask

    task automatic test_fault();
        int n = 0;
        I_set = 13'd2048; SW_ON = 1'b1; LD_ON = 1'b1;
        while (I_out !== 13'd1500 && n < 5000) begin @(negedge CLK); n++; end
        chk_cnt++; if (I_out !== 13'd1500) $display("FAIL fault_reach_1500 got=%0d exp=1500", I_out); else pass_cnt++;
        chk_cnt++; if (state !== 3'd1) $display("FAIL fault_pre_state got=%0d exp=1", state); else pass_cnt++;
        FAULT = 1'b1;
        @(negedge CLK);
        FAULT = 1'b0;
        chk_cnt++; if (I_out !== 13'd0) $display("FAIL fault_i_out got=%0d exp=0", I_out); else pass_cnt++;
        chk_cnt++; if (state !== 3'd5) $display("FAIL fault_state got=%0d exp=5", state); else pass_cnt++;
        chk_cnt++; if (fault_latched !== 1'b1) $display("FAIL fault_latched got=%b exp=1", fault_latched); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL fault_busy got=%b exp=0", busy); else pass_cnt++;
        repeat (5) @(negedge CLK);
        chk_cnt++; if (state !== 3'd5) $display("FAIL fault_sticky got=%0d exp=5", state); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd0) $display("FAIL fault_hold_zero got=%0d exp=0", I_out); else pass_cnt++;
        SW_ON = 1'b0;
        @(negedge CLK);
        chk_cnt++; if (state !== 3'd0) $display("FAIL fault_release got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if (fault_latched !== 1'b0) $display("FAIL fault_release_flag got=%b exp=0", fault_latched); else pass_cnt++;
    endtask

    task automatic test_clr_mid_ramp();
        I_set = 13'd2048; SW_ON = 1'b1; LD_ON = 1'b1;
        repeat (50) @(negedge CLK);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL clr_pre_busy got=%b exp=1", busy); else pass_cnt++;
        chk_cnt++; if (I_out !== 13'd24) $display("FAIL clr_pre_i_out got=%0d exp=24", I_out); else pass_cnt++;
        Clr = 1'b1;
        @(negedge CLK);
        chk_cnt++; if (I_out !== 13'd0) $display("FAIL clr_i_out got=%0d exp=0", I_out); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL clr_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if ({at_set, busy, fault_latched} !== 3'b000)
            $display("FAIL clr_flags got=%b exp=000", {at_set, busy, fault_latched}); else pass_cnt++;
        Clr = 1'b0; SW_ON = 1'b0; LD_ON = 1'b0;
        @(negedge CLK);
        chk_cnt++; if (state !== 3'd0) $display("FAIL clr_after_release got=%0d exp=0", state); else pass_cnt++;
    endtask

    // Scenario sequence and summary.
    initial begin
        Clr = 1'b1; SW_ON = 1'b0; LD_ON = 1'b0; FAULT = 1'b0; I_set = '0;
        test_reset();
        test_soft_start();
        test_soft_stop();
        test_small_setpoint();
        test_tracking();
        test_saturation();
        test_fault();
        test_clr_mid_ramp();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
